// File: rtl/seq_feeder.sv
`default_nettype none
// ============================================================================
// Module   : seq_feeder
// Purpose  : Upstream loader for the systolic PE array. Accepts an ASCII
//            nucleotide stream (valid/ready) and 2-bit encodes each base
//            (A=00 C=01 G=10 T=11, case-insensitive, other bytes -> 00).
//            The first N_PE bases form the query packed on o_B. The
//            following bases (up to MAX_A, ended by i_last) are buffered as
//            the reference. The buffered reference is then played out one
//            base per cycle on o_A while o_start is high, followed by a
//            DRAIN_CYC idle window that ends with an o_done pulse.
// Ports    : i_clk, i_rst (sync, active high)
//            i_valid/o_ready/i_data/i_last : character input handshake
//            o_start/o_A/o_B               : drive to the PE array
//            o_len_A                       : reference length of current job
//            o_busy, o_done                : job status
//            o_bad_char                    : sticky non-ACGT flag, only
//                                            present with FEEDER_BAD_CHAR_EN
// Macro    : FEEDER_BAD_CHAR_EN enables the o_bad_char port and logic.
// Revision : 1.0 - initial release
// ============================================================================
module seq_feeder #(
  parameter int N_PE      = 64,
  parameter int MAX_A     = 200,
  parameter int DRAIN_CYC = N_PE + 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [7:0]                   i_data,
  input  logic                         i_last,
  output logic                         o_start,
  output logic [1:0]                   o_A,
  output logic [2*N_PE-1:0]            o_B,
  output logic [$clog2(MAX_A+1)-1:0]   o_len_A,
  output logic                         o_busy,
`ifdef FEEDER_BAD_CHAR_EN
  output logic                         o_bad_char,
`endif
  output logic                         o_done
);

  localparam int LW = $clog2(MAX_A + 1);
  localparam int BW = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int DW = $clog2(DRAIN_CYC + 1);

  localparam logic [1:0] S_LOAD_B = 2'd0;
  localparam logic [1:0] S_LOAD_A = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [BW-1:0] b_cnt;
  logic [LW-1:0] a_cnt;
  logic [LW-1:0] run_idx;
  logic [LW-1:0] nxt_idx;
  logic [DW-1:0] drain_cnt;
  logic [1:0]    ref_buf [MAX_A];
  logic [1:0]    code;
  logic          xfer;
  logic          b_end;
  logic          a_end;
  logic          run_end;
  logic          drain_last;

  // ASCII to 2-bit base code
  always_comb begin
    code = 2'b00;
    case (i_data)
      8'h43, 8'h63: code = 2'b01;  // C c
      8'h47, 8'h67: code = 2'b10;  // G g
      8'h54, 8'h74: code = 2'b11;  // T t
      default:      code = 2'b00;  // A a, and anything else
    endcase
  end

  assign xfer       = i_valid & o_ready;
  assign b_end      = (state == S_LOAD_B) && xfer && (b_cnt == BW'(N_PE - 1));
  // Reference load ends on i_last or when the buffer becomes full.
  assign a_end      = (state == S_LOAD_A) && xfer &&
                      (i_last || (a_cnt == LW'(MAX_A - 1)));
  assign nxt_idx    = run_idx + 1'b1;
  assign run_end    = (nxt_idx == o_len_A);
  assign drain_last = (drain_cnt == DW'(DRAIN_CYC - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_LOAD_B;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD_B: if (b_end)      state_nxt = S_LOAD_A;
      S_LOAD_A: if (a_end)      state_nxt = S_RUN;
      S_RUN:    if (run_end)    state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_last) state_nxt = S_LOAD_B;
      default:                  state_nxt = S_LOAD_B;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    o_ready = (state == S_LOAD_B) || (state == S_LOAD_A);
    o_busy  = (state == S_RUN) || (state == S_DRAIN);
    o_done  = (state == S_DRAIN) && drain_last;
  end

  // Reference buffer: no reset needed, only read back after being written.
  always_ff @(posedge i_clk) begin
    if ((state == S_LOAD_A) && xfer) ref_buf[a_cnt] <= code;
  end

  // Counters and registered array-side outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      b_cnt     <= '0;
      a_cnt     <= '0;
      run_idx   <= '0;
      drain_cnt <= '0;
      o_start   <= 1'b0;
      o_A       <= 2'b00;
      o_B       <= '0;
      o_len_A   <= '0;
    end else begin
      case (state)
        S_LOAD_B: begin
          if (xfer) begin
            o_B[{b_cnt, 1'b0} +: 2] <= code;
            b_cnt <= b_end ? '0 : b_cnt + 1'b1;
          end
        end
        S_LOAD_A: begin
          if (xfer) begin
            a_cnt <= a_cnt + 1'b1;
            if (a_end) begin
              o_len_A <= a_cnt + 1'b1;
              a_cnt   <= '0;
              run_idx <= '0;
              o_start <= 1'b1;
              // Base 0 may be arriving on this very edge (len_A==1), so
              // forward it instead of reading the not-yet-written buffer.
              o_A     <= (a_cnt == '0) ? code : ref_buf[0];
            end
          end
        end
        S_RUN: begin
          // o_A is fetched one cycle ahead so bases stream without bubbles.
          if (run_end) begin
            o_start   <= 1'b0;
            o_A       <= 2'b00;
            drain_cnt <= '0;
          end else begin
            o_A     <= ref_buf[nxt_idx];
            run_idx <= nxt_idx;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_last ? '0 : drain_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FEEDER_BAD_CHAR_EN
  logic is_bad;
  logic bad_flag;

  always_comb begin
    is_bad = 1'b1;
    case (i_data)
      8'h41, 8'h61, 8'h43, 8'h63, 8'h47, 8'h67, 8'h54, 8'h74: is_bad = 1'b0;
      default: is_bad = 1'b1;
    endcase
  end

  // Sticky per job; the first query char of a new job restarts the flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bad_flag <= 1'b0;
    end else if (xfer) begin
      if ((state == S_LOAD_B) && (b_cnt == '0)) bad_flag <= is_bad;
      else                                      bad_flag <= bad_flag | is_bad;
    end
  end

  assign o_bad_char = bad_flag;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_feeder
// Purpose  : Self-checking bench for seq_feeder. A character stream is built
//            by the stimulus; a stream-level model splits it into jobs and
//            queues the expected o_B, length and o_A sequence. A monitor
//            compares every o_start burst and the o_done timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_feeder;
  localparam int N_PE      = 64;
  localparam int MAX_A     = 200;
  localparam int DRAIN_CYC = N_PE + 2;
  localparam int LW        = $clog2(MAX_A + 1);
  localparam int BWID      = 2 * N_PE;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid = 1'b0;
  logic              last = 1'b0;
  logic [7:0]        data = 8'h00;
  logic              ready, start, busy, done;
  logic [1:0]        a_out;
  logic [BWID-1:0]   b_out;
  logic [LW-1:0]     len_out;
`ifdef FEEDER_BAD_CHAR_EN
  logic              bad_char;
`endif

  seq_feeder #(.N_PE(N_PE), .MAX_A(MAX_A), .DRAIN_CYC(DRAIN_CYC)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_data(data), .i_last(last), .o_start(start), .o_A(a_out),
    .o_B(b_out), .o_len_A(len_out), .o_busy(busy),
`ifdef FEEDER_BAD_CHAR_EN
    .o_bad_char(bad_char),
`endif
    .o_done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  byte             drv_c[$];
  bit              drv_l[$];
  byte             mdl_c[$];
  bit              mdl_l[$];
  logic [BWID-1:0] exp_b[$];
  int              exp_len[$];
  logic [1:0]      exp_a[$];

  int gap_pct   = 0;
  bit mon_en    = 1'b1;
  bit abort     = 1'b0;
  int jobs_exp  = 0;
  int jobs_done = 0;

  task automatic chk(input string nm, input logic [BWID-1:0] act, input logic [BWID-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input byte c);
    string s = "ACGTacgt";
    for (int i = 0; i < 8; i++)
      if (s[i] == c) return 2'(i % 4);
    return 2'b00;
  endfunction

  function automatic byte rand_char(input bit allow_bad);
    string s = "ACGTacgtNx";
    return s[allow_bad ? $urandom_range(9) : $urandom_range(7)];
  endfunction

  // Split the pending stream into jobs: N_PE query chars (i_last ignored),
  // then reference chars up to the first i_last or MAX_A chars.
  task automatic model_parse();
    forever begin
      int end_j = -1;
      logic [BWID-1:0] b;
      if (mdl_c.size() < N_PE + 1) break;
      for (int j = 0; j < MAX_A && N_PE + j < mdl_c.size(); j++) begin
        if (mdl_l[N_PE + j] || j == MAX_A - 1) begin
          end_j = j;
          break;
        end
      end
      if (end_j < 0) break;
      b = '0;
      for (int k = 0; k < N_PE; k++) b[2*k +: 2] = enc(mdl_c[k]);
      exp_b.push_back(b);
      exp_len.push_back(end_j + 1);
      for (int j = 0; j <= end_j; j++) exp_a.push_back(enc(mdl_c[N_PE + j]));
      for (int j = 0; j < N_PE + end_j + 1; j++) begin
        void'(mdl_c.pop_front());
        void'(mdl_l.pop_front());
      end
      jobs_exp++;
    end
  endtask

  task automatic push(input byte c, input bit l);
    drv_c.push_back(c); drv_l.push_back(l);
    mdl_c.push_back(c); mdl_l.push_back(l);
  endtask

  task automatic push_str(input string s, input bit last_on_end);
    for (int i = 0; i < s.len(); i++) push(s[i], last_on_end && (i == s.len() - 1));
  endtask

  task automatic push_rep(input byte c, input int n);
    for (int i = 0; i < n; i++) push(c, 1'b0);
  endtask

  task automatic drive_all();
    while (drv_c.size() > 0 && !abort) begin
      byte c = drv_c.pop_front();
      bit  l = drv_l.pop_front();
      int  w = 0;
      @(negedge clk);
      while ($urandom_range(99) < gap_pct) begin
        valid = 1'b0;
        @(negedge clk);
      end
      valid = 1'b1; data = c; last = l;
      while (!ready) begin
        @(negedge clk);
        w++;
        if (w > 2000) begin
          checks++; errors++;
          $display("FAIL accept_timeout: o_ready low for %0d cycles, required high", w);
          abort = 1'b1;
          break;
        end
      end
      @(posedge clk);
      #1 valid = 1'b0; last = 1'b0;
    end
    drv_c.delete(); drv_l.delete();
  endtask

  bit prev_start = 1'b0;
  bit in_drain   = 1'b0;
  int run_cnt    = 0;
  int cur_len    = 0;
  int low_cnt    = 0;

  task automatic wait_idle();
    int n = 0;
    while (!(exp_len.size() == 0 && exp_a.size() == 0 && !in_drain && jobs_done == jobs_exp)) begin
      @(negedge clk);
      n++;
      if (n > 20000) begin
        checks++; errors++;
        $display("FAIL idle_timeout: jobs done %0d, required %0d", jobs_done, jobs_exp);
        abort = 1'b1;
        break;
      end
    end
  endtask

  // Monitor: samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      in_drain = 1'b0;
    end else if (mon_en) begin
      if (start && !prev_start) begin
        if (exp_len.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: o_start=1 with no job queued, required 0");
        end else begin
          chk("o_B", b_out, exp_b.pop_front());
          cur_len = exp_len.pop_front();
          chk("o_len_A", BWID'(len_out), BWID'(cur_len));
          run_cnt = 0;
        end
      end
      if (start) begin
        chk("o_busy_run", BWID'(busy), BWID'(1'b1));
        chk("o_ready_run", BWID'(ready), BWID'(1'b0));
        if (exp_a.size() > 0) chk("o_A", BWID'(a_out), BWID'(exp_a.pop_front()));
        run_cnt++;
      end
      if (!start && prev_start) begin
        chk("run_length", BWID'(run_cnt), BWID'(cur_len));
        in_drain = 1'b1;
        low_cnt  = 0;
      end
      if (in_drain) begin
        low_cnt++;
        chk("o_A_idle", BWID'(a_out), BWID'(2'b00));
        if (done) begin
          chk("done_timing", BWID'(low_cnt), BWID'(DRAIN_CYC));
          in_drain = 1'b0;
          jobs_done++;
        end else if (low_cnt > DRAIN_CYC) begin
          checks++; errors++;
          $display("FAIL done_missing: no o_done after %0d cycles, required %0d", low_cnt, DRAIN_CYC);
          in_drain = 1'b0;
          jobs_done++;
        end
      end else if (done) begin
        checks++; errors++;
        $display("FAIL unexpected_done: o_done=1 outside drain, required 0");
      end
    end
    prev_start = start;
  end

  initial begin
    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", BWID'(ready), BWID'(1'b1));
    chk("rst_start", BWID'(start), BWID'(1'b0));
    chk("rst_B", b_out, '0);
    chk("rst_busy", BWID'(busy), BWID'(1'b0));
    chk("rst_len", BWID'(len_out), '0);
    chk("rst_done", BWID'(done), BWID'(1'b0));
    rst = 1'b0;

    // 64 x 'A' then ACGT
    push_rep("A", N_PE); push_str("ACGT", 1'b1);
    model_parse(); drive_all(); wait_idle();

    // lower-case query, single-base reference
    push_rep("c", N_PE); push_str("g", 1'b1);
    model_parse(); drive_all(); wait_idle();

    // buffer overflow: the 5 extra G start the next query
    push_rep("T", N_PE); push_rep("G", MAX_A + 5);
    push_rep("A", N_PE - 5); push_str("CAT", 1'b1);
    model_parse(); drive_all(); wait_idle();

    // same stream as the first job with 50% valid gaps
    gap_pct = 50;
    push_rep("A", N_PE); push_str("ACGT", 1'b1);
    model_parse(); drive_all(); wait_idle();

    // random jobs, random query-side i_last, occasional overlong references
    for (int r = 0; r < 6 && !abort; r++) begin
      int len = $urandom_range(MAX_A + 8, 1);
      gap_pct = $urandom_range(60);
      for (int k = 0; k < N_PE; k++) push(rand_char(1'b1), $urandom_range(3) == 0);
      for (int j = 0; j < len; j++) push(rand_char(1'b1), (j == len - 1) && (len <= MAX_A));
    end
    push_rep("A", N_PE); push_str("C", 1'b1);
    model_parse(); drive_all(); wait_idle();
    gap_pct = 0;

    // reset during RUN cycle 2 aborts the job
    if (!abort) begin
      mon_en = 1'b0;
      for (int k = 0; k < N_PE; k++) begin drv_c.push_back("T"); drv_l.push_back(1'b0); end
      for (int k = 0; k < MAX_A; k++) begin drv_c.push_back("G"); drv_l.push_back(1'b0); end
      drive_all();
      @(negedge clk);
      chk("run_cycle1_start", BWID'(start), BWID'(1'b1));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_start", BWID'(start), BWID'(1'b0));
      chk("abort_ready", BWID'(ready), BWID'(1'b1));
      chk("abort_B", b_out, '0);
      chk("abort_busy", BWID'(busy), BWID'(1'b0));
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;
    end

`ifdef FEEDER_BAD_CHAR_EN
    if (!abort) begin
      push_rep("A", 10); push_str("N", 1'b0); push_rep("A", N_PE - 11); push_str("G", 1'b1);
      model_parse(); drive_all(); wait_idle();
      chk("bad_char_set", BWID'(bad_char), BWID'(1'b1));
      push_str("A", 1'b0);
      drive_all();
      @(negedge clk);
      chk("bad_char_clear", BWID'(bad_char), BWID'(1'b0));
      push_rep("A", N_PE - 1); push_str("T", 1'b1);
      model_parse(); drive_all(); wait_idle();
    end
`endif

    chk("jobs_completed", BWID'(jobs_done), BWID'(jobs_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
